// File: rtl/mod_aes_pkg.sv
// Shared definitions for the M-AES-128 round engine: FSM state type,
// block and round-counter widths, S-box/rcon tables and the modular
// word adder used between shiftrow and mixcolumn.
package mod_aes_pkg;

    localparam int RC_W  = 4;
    localparam int BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [10:0] idx;
        // ~b equals 255-b, which locates entry b counting from the LSB end
        idx = {~b, 3'b000};
        return SBOX_TABLE[idx +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
        logic [7:0] r;
        case (rc)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            4'd11:   r = 8'h6c;
            4'd12:   r = 8'hd8;
            4'd13:   r = 8'hab;
            4'd14:   r = 8'h4d;
            4'd15:   r = 8'h9a;
            default: r = 8'h8d;
        endcase
        return r;
    endfunction

    // Sum formed at 33 bits so no carry is lost, then reduced mod 2^mod_bits.
    function automatic logic [31:0] mod_add_word(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input int          mod_bits);
        logic [32:0] sum;
        logic [32:0] mask;
        sum = {1'b0, a} + {1'b0, b};
        if (mod_bits >= 32)
            mask = {1'b0, 32'hffff_ffff};
        else
            mask = (33'd1 << mod_bits) - 33'd1;
        return sum[31:0] & mask[31:0];
    endfunction

endpackage

// File: rtl/mod_aes_primitives.sv
// AES building blocks shared by the round datapath: key expansion step,
// byte substitution, row shift and column mix on a 128-bit state whose
// byte 0 sits in bits [127:120] and columns are consecutive 32-bit words.
module Key_Generation
    import mod_aes_pkg::*;
(
    input  logic [RC_W-1:0]  rc,
    input  logic [BLK_W-1:0] key_in,
    output logic [BLK_W-1:0] key_out
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, tmp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_in;
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {sbox_byte(rot[31:24]), sbox_byte(rot[23:16]),
                  sbox_byte(rot[15:8]),  sbox_byte(rot[7:0])};
    assign tmp = sub ^ {rcon(rc), 24'h000000};
    assign n0  = w0 ^ tmp;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};
endmodule

module subbytes
    import mod_aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_in,
    output logic [BLK_W-1:0] data_out
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign data_out[8*i +: 8] = sbox_byte(data_in[8*i +: 8]);
    end
endmodule

module shiftrow
    import mod_aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_in,
    output logic [BLK_W-1:0] data_out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign data_out[127-8*(r+4*c) -: 8] = data_in[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

module mixcolumn
    import mod_aes_pkg::*;
(
    input  logic [BLK_W-1:0] data_in,
    output logic [BLK_W-1:0] data_out
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = data_in[127-32*c -: 32];
        assign data_out[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end
endmodule

// File: rtl/mod_aes_round_engine_round_comb.sv
// One M-AES round, purely combinational. Three chained key expansions
// share the same rc; the middle key feeds the modular adder and the last
// key whitens the result and becomes the next round key.
// MOD_AES_FINAL_NO_MIX_EN: when defined, the last round skips mixcolumn.
module mod_aes_round_comb
    import mod_aes_pkg::*;
#(
    parameter int MOD_BITS = 5
) (
    input  logic [BLK_W-1:0] st,
    input  logic [BLK_W-1:0] k,
    input  logic [RC_W-1:0]  rc,
    input  logic             last_round,
    output logic [BLK_W-1:0] st_next,
    output logic [BLK_W-1:0] k_next
);
    logic [BLK_W-1:0] k0, k1, k2;
    logic [BLK_W-1:0] sb, x, s, m, mc;

    Key_Generation u_kg0 (.rc(rc), .key_in(k),  .key_out(k0));
    Key_Generation u_kg1 (.rc(rc), .key_in(k0), .key_out(k1));
    Key_Generation u_kg2 (.rc(rc), .key_in(k1), .key_out(k2));

    subbytes u_sb (.data_in(st), .data_out(sb));
    assign x = sb ^ k0;
    shiftrow u_sr (.data_in(x), .data_out(s));

    for (genvar i = 0; i < 4; i++) begin : g_add
        assign m[32*i +: 32] = mod_add_word(k1[32*i +: 32], s[32*i +: 32], MOD_BITS);
    end

    mixcolumn u_mc (.data_in(m), .data_out(mc));

`ifdef MOD_AES_FINAL_NO_MIX_EN
    assign st_next = (last_round ? m : mc) ^ k2;
`else
    logic unused_last_round;
    assign unused_last_round = last_round;
    assign st_next = mc ^ k2;
`endif

    assign k_next = k2;
endmodule

// File: rtl/mod_aes_round_engine.sv
// Iterative M-AES-128 engine: accepts a block/key, runs NUM_ROUNDS rounds
// one per clock through a shared round datapath, then presents the
// ciphertext and final key until the consumer takes them.
// MOD_AES_FINAL_NO_MIX_EN: when defined, the last round skips mixcolumn.
module mod_aes_round_engine
    import mod_aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int MOD_BITS   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] data_in,
    input  logic [BLK_W-1:0] key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] data_out,
    output logic [BLK_W-1:0] key_out,
    output logic             busy
);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS);

    state_t           state, state_next;
    logic [BLK_W-1:0] st, k;
    logic [BLK_W-1:0] st_nxt, k_nxt;
    logic [RC_W-1:0]  rc;
    logic             last_round;

    assign last_round = (rc == RC_LAST);

    mod_aes_round_comb #(.MOD_BITS(MOD_BITS)) u_round (
        .st         (st),
        .k          (k),
        .rc         (rc),
        .last_round (last_round),
        .st_next    (st_nxt),
        .k_next     (k_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state: accept in IDLE, finish after the last round, release on out_ready.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = ROUND;
            ROUND:   if (last_round) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == ROUND);
    end

    // Working state, key and round counter: load on accept, advance each round.
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= '0;
            k  <= '0;
            rc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st <= data_in;
                        k  <= key_in;
                        rc <= RC_W'(1);
                    end
                end
                ROUND: begin
                    st <= st_nxt;
                    k  <= k_nxt;
                    rc <= rc + RC_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: capture the last round, hold through DONE, clear on hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            key_out  <= '0;
        end else if (state == ROUND && last_round) begin
            data_out <= st_nxt;
            key_out  <= k_nxt;
        end else if (state == DONE && out_ready) begin
            data_out <= '0;
            key_out  <= '0;
        end
    end

endmodule

// File: tb/tb_mod_aes_round_engine.sv
// Directed bench for mod_aes_round_engine: two instances (MOD_BITS 5 and 32)
// share stimulus; results are compared against a byte-level reference model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
// MOD_AES_FINAL_NO_MIX_EN selects the matching final-round model.
module tb_mod_aes_round_engine;
    import mod_aes_pkg::*;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] data_in = '0;
    logic [127:0] key_in = '0;

    logic         in_ready5, out_valid5, busy5;
    logic [127:0] data_out5, key_out5;
    logic         in_ready32, out_valid32, busy32;
    logic [127:0] data_out32, key_out32;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    logic [7:0] sbox_model [256];

    mod_aes_round_engine #(.NUM_ROUNDS(NR), .MOD_BITS(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .data_in(data_in), .key_in(key_in), .out_valid(out_valid5),
        .out_ready(out_ready), .data_out(data_out5), .key_out(key_out5),
        .busy(busy5)
    );

    mod_aes_round_engine #(.NUM_ROUNDS(NR), .MOD_BITS(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .data_in(data_in), .key_in(key_in), .out_valid(out_valid32),
        .out_ready(out_ready), .data_out(data_out32), .key_out(key_out32),
        .busy(busy32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        if (x == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_keygen(input int rc, input logic [127:0] k);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rcv;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        t = {w[3][23:0], w[3][31:24]};
        t = {sbox_model[t[31:24]], sbox_model[t[23:16]], sbox_model[t[15:8]], sbox_model[t[7:0]]};
        rcv = 8'h01;
        for (int i = 1; i < rc; i++) rcv = gmul(rcv, 8'h02);
        t[31:24] = t[31:24] ^ rcv;
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    function automatic logic [127:0] model_sub(input logic [127:0] v);
        logic [127:0] r;
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = sbox_model[v[127-8*n -: 8]];
        return r;
    endfunction

    // Row r of the 4x4 state rotates left by r column positions.
    function automatic logic [127:0] model_shift(input logic [127:0] v);
        logic [7:0] grid [4][4];
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                grid[row][c] = v[127-8*(4*c+row) -: 8];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                r[127-8*(4*c+row) -: 8] = grid[row][(c+row)%4];
        return r;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] v);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = v[127-32*c -: 32];
            r[127-32*c -: 32] = {
                gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
        end
        return r;
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b, input int mb);
        logic [63:0] s;
        logic [63:0] modulus;
        s = {32'd0, a} + {32'd0, b};
        modulus = 64'd1 << mb;
        s = s % modulus;
        return s[31:0];
    endfunction

    function automatic void model_block(input logic [127:0] d, input logic [127:0] key, input int mb,
                                        output logic [127:0] c_out, output logic [127:0] k_out);
        logic [127:0] s, kk, k0, k1, k2, sh, m;
        s = d; kk = key;
        for (int r = 1; r <= NR; r++) begin
            k0 = model_keygen(r, kk);
            k1 = model_keygen(r, k0);
            k2 = model_keygen(r, k1);
            sh = model_shift(model_sub(s) ^ k0);
            for (int i = 0; i < 4; i++) m[32*i +: 32] = model_add(k1[32*i +: 32], sh[32*i +: 32], mb);
`ifdef MOD_AES_FINAL_NO_MIX_EN
            if (r == NR) s = m ^ k2;
            else         s = model_mix(m) ^ k2;
`else
            s = model_mix(m) ^ k2;
`endif
            kk = k2;
        end
        c_out = s;
        k_out = kk;
    endfunction

    // ---------------- check / drive tasks ----------------
    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a clock edge; returns accept cycle and accept-to-out_valid latency.
    task automatic apply_stimulus(input logic [127:0] d, input logic [127:0] k,
                                  output int acc_cycle, output int lat);
        int n;
        n = 0;
        while (!in_ready5 && n < 50) begin @(posedge clk); #1; n++; end
        check_output("in_ready_wait", {127'd0, in_ready5}, 128'd1);
        data_in = d; key_in = k; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cycle = cycle;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid5 && n < 50) begin @(posedge clk); #1; n++; end
        check_output("out_valid_wait", {127'd0, out_valid5}, 128'd1);
        lat = cycle - acc_cycle;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] d, k, e5, ek5, e32, ek32;
        int acc, lat, prev_acc;

        for (int i = 0; i < 256; i++) sbox_model[i] = sbox_calc(8'(i));

        // Reset held three cycles, then idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_output("rst_in_ready",   {127'd0, in_ready5},  128'd1);
        check_output("rst_out_valid",  {127'd0, out_valid5}, 128'd0);
        check_output("rst_busy",       {127'd0, busy5},      128'd0);
        check_output("rst_data_out",   data_out5,            128'd0);
        check_output("rst_key_out",    key_out5,             128'd0);
        check_output("rst_in_ready32", {127'd0, in_ready32}, 128'd1);
        check_output("rst_busy32",     {127'd0, busy32},     128'd0);
        check_output("rst_data_out32", data_out32,           128'd0);

        // Package adder boundaries
        check_output("add32_wrap", {96'd0, mod_add_word(32'hffff_ffff, 32'h1, 32)}, 128'd0);
        check_output("add5_wrap",  {96'd0, mod_add_word(32'h1f, 32'h1, 5)},         128'd0);
        check_output("add5_carry", {96'd0, mod_add_word(32'hffff_ffff, 32'hffff_ffff, 5)}, 128'h1e);
        check_output("add5_plain", {96'd0, mod_add_word(32'h3, 32'h4, 5)},          128'h7);

        // Single block with out_ready low
        d = 128'h00112233445566778899aabbccddeeff;
        k = 128'h000102030405060708090a0b0c0d0e0f;
        model_block(d, k, 5, e5, ek5);
        model_block(d, k, 32, e32, ek32);
        out_ready = 1'b0;
        data_in = d; key_in = k; in_valid = 1'b1;
        @(posedge clk); #1;
        acc = cycle;
        in_valid = 1'b0;
        check_output("round_busy",      {127'd0, busy5},      128'd1);
        check_output("round_in_ready",  {127'd0, in_ready5},  128'd0);
        check_output("round_out_valid", {127'd0, out_valid5}, 128'd0);
        check_output("round_data_out",  data_out5,            128'd0);
        begin
            int n;
            n = 0;
            while (!out_valid5 && n < 50) begin @(posedge clk); #1; n++; end
        end
        check_output("single_valid",   {127'd0, out_valid5}, 128'd1);
        check_output("single_latency", 128'(cycle - acc),    128'd10);
        check_output("single_data5",   data_out5,  e5);
        check_output("single_key5",    key_out5,   ek5);
        check_output("single_data32",  data_out32, e32);
        check_output("single_key32",   key_out32,  ek32);

        // Backpressure for 20 cycles, with an ignored in_valid pulse
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                data_in = ~d; key_in = ~k; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_output("bp_data",      data_out5,            e5);
            check_output("bp_key",       key_out5,             ek5);
            check_output("bp_out_valid", {127'd0, out_valid5}, 128'd1);
            check_output("bp_in_ready",  {127'd0, in_ready5},  128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_output("rel_out_valid", {127'd0, out_valid5}, 128'd0);
        check_output("rel_in_ready",  {127'd0, in_ready5},  128'd1);
        check_output("rel_data_out",  data_out5,            128'd0);
        check_output("rel_key_out",   key_out5,             128'd0);
        @(posedge clk); #1;
        check_output("rel_no_queue",  {127'd0, busy5},      128'd0);

        // All-ones key: MOD_BITS 5 and 32 diverge
        d = 128'h0123456789abcdeffedcba9876543210;
        k = {128{1'b1}};
        model_block(d, k, 5, e5, ek5);
        model_block(d, k, 32, e32, ek32);
        apply_stimulus(d, k, acc, lat);
        check_output("ones_latency", 128'(lat), 128'd10);
        check_output("ones_data5",   data_out5,  e5);
        check_output("ones_key5",    key_out5,   ek5);
        check_output("ones_data32",  data_out32, e32);
        check_output("ones_key32",   key_out32,  ek32);
        check_output("ones_differ",  {127'd0, data_out5 !== data_out32}, 128'd1);

        // Reset during round 4 discards the block
        @(posedge clk); #1;
        data_in = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        key_in  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_output("abort_busy",      {127'd0, busy5},      128'd0);
        check_output("abort_in_ready",  {127'd0, in_ready5},  128'd1);
        check_output("abort_out_valid", {127'd0, out_valid5}, 128'd0);
        check_output("abort_data_out",  data_out5,            128'd0);
        d = 128'h3243f6a8885a308d313198a2e0370734;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_block(d, k, 5, e5, ek5);
        model_block(d, k, 32, e32, ek32);
        apply_stimulus(d, k, acc, lat);
        check_output("after_abort_latency", 128'(lat), 128'd10);
        check_output("after_abort_data5",   data_out5,  e5);
        check_output("after_abort_key5",    key_out5,   ek5);
        check_output("after_abort_data32",  data_out32, e32);
        check_output("after_abort_key32",   key_out32,  ek32);

        // Back-to-back random blocks with out_ready held high
        prev_acc = 0;
        for (int b = 0; b < 50; b++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_block(d, k, 5, e5, ek5);
            model_block(d, k, 32, e32, ek32);
            apply_stimulus(d, k, acc, lat);
            if (b > 0) check_output("b2b_interval", 128'(acc - prev_acc), 128'd12);
            prev_acc = acc;
            check_output("b2b_latency", 128'(lat), 128'd10);
            check_output("b2b_data5",   data_out5,  e5);
            check_output("b2b_key5",    key_out5,   ek5);
            check_output("b2b_data32",  data_out32, e32);
            check_output("b2b_key32",   key_out32,  ek32);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_aes_round_engine.md
# mod_aes_round_engine

Iterative, parametrised M-AES-128 encryption engine. Accepts one 128-bit block and 128-bit key over a valid/ready handshake, applies `NUM_ROUNDS` modified-AES rounds, one per clock, through a single shared round datapath, and returns the ciphertext and final round key over a second handshake. It replaces the single combinational round used at top level with a self-sequencing unit. The modular-addition width is configurable.

## Interface
- `NUM_ROUNDS`, default 10: rounds per block; legal range 1..15 (rc is 4 bits).
- `MOD_BITS`, default 5: modular-add width per 32-bit word, giving mod 2^MOD_BITS; legal range 1..32. 32 means plain 32-bit wrap.

- `clk` input 1: sole clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `data_in`/`key_in` valid.
- `in_ready` output 1: engine can accept a block.
- `data_in` input 128: plaintext block.
- `key_in` input 128: initial key.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `data_out` output 128: ciphertext.
- `key_out` output 128: key after the last round.
- `busy` output 1: high in ROUND state.

## Operation
- FSM states and transitions:
  - IDLE → ROUND on `in_valid & in_ready`.
  - ROUND → DONE when the round counter equals `NUM_ROUNDS`.
  - DONE → IDLE on `out_ready`.
- On accept:
  - `st <= data_in`, `k <= key_in`, `rc <= 1`.
  - No pre-whitening.
- Each ROUND cycle computes, from `st`, `k` and `rc`:
  - `k0 = keygen(rc, k)`, `k1 = keygen(rc, k0)`, `k2 = keygen(rc, k1)`. All three expansions use the same rc.
  - `x = subbytes(st) ^ k0`.
  - `s = shiftrow(x)`.
  - `m[32i+:32] = (k1[32i+:32] + s[32i+:32]) mod 2^MOD_BITS`, zero-extended to 32 bits, for i = 0..3. The sum is formed at 33 bits before reduction, so there is no lost carry.
  - `st <= mixcolumn(m) ^ k2`, `k <= k2`, `rc <= rc + 1`.
- In DONE:
  - `data_out = st`, `key_out = k`, held stable while `out_valid & !out_ready`.
- `in_ready` is 1 only in IDLE. `in_valid` in ROUND or DONE is ignored and never queued.
- `out_valid` is 1 only in DONE.
- Reset values: state IDLE, `in_ready` = 1 from the cycle after reset release, `out_valid` = 0, `busy` = 0, `data_out` = 0, `key_out` = 0, `rc` = 0.
- Reset asserted mid-ROUND or in DONE discards the block. The next cycle is IDLE with zeroed outputs.
- `data_out`/`key_out` are registered and read 0 outside DONE.

## Timing
- Accept at edge T. Rounds execute on edges T+1..T+NUM_ROUNDS. `out_valid` is high after edge T+NUM_ROUNDS.
- Latency from accept to `out_valid` is NUM_ROUNDS cycles.
- `out_ready` high on the first DONE cycle returns to IDLE next cycle. The new accept can occur one cycle later.
- Minimum initiation interval is NUM_ROUNDS+2 cycles.
- Backpressure extends DONE indefinitely with no change to outputs.
- Critical path: three chained keygens plus subbytes→shiftrow→adder→mixcolumn in one cycle.

## Configuration
- `MOD_AES_FINAL_NO_MIX_EN`:
  - Defined: the round with `rc == NUM_ROUNDS` bypasses mixcolumn, so `st <= m ^ k2`. This is standard AES final-round behaviour.
  - Undefined: every round, including the last, applies mixcolumn.
- Control and latency are identical in both builds.

## Structure
- Shared package `mod_aes_pkg` holds:
  - FSM state enum (IDLE, ROUND, DONE).
  - `RC_W = 4` and `BLK_W = 128`.
  - A `mod_add_word` function parametrised on MOD_BITS.
- The round datapath is one sub-module, `mod_aes_round_comb`. It is purely combinational: inputs are `st`, `k`, `rc` and the last-round flag; outputs are next `st` and next `k`. It instantiates the existing `Key_Generation`, `subbytes`, `shiftrow` and `mixcolumn`.
- The top holds only the FSM, counter and registers.

## Test plan
- Reset then idle: hold `rst` 3 cycles, release → `in_ready` = 1, `out_valid` = 0, `data_out` = `key_out` = 0.
- Single block, NUM_ROUNDS = 10, MOD_BITS = 5, `data_in` = 0x00112233445566778899aabbccddeeff, `key_in` = 0x000102030405060708090a0b0c0d0e0f, accepted at cycle 0 → `out_valid` rises at cycle 10. `data_out`/`key_out` bit-exactly match the C golden model of the round chain with rc 1..10.
- Backpressure: `out_ready` held 0 for 20 cycles after `out_valid` → outputs constant, `in_ready` = 0, and an `in_valid` pulse during this window is ignored.
- MOD_BITS = 32 versus MOD_BITS = 5 with `key_in` = all-ones → results differ and each matches its model. The MOD_BITS = 32 adder wraps 0xffffffff + 1 to 0.
- Reset at round 4, then new block → result matches the model for the new block only. No residue of the aborted block.
- Back-to-back, 50 random blocks with `out_ready` = 1 → initiation interval is exactly 12 cycles, all results match. Run with `MOD_AES_FINAL_NO_MIX_EN` both defined and undefined against the matching model.
